ifu_prefetch: RTL and testbench
===============================

IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the instruction-buffer entry count (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h8000_0000, SHALL set the first fetch address after reset.
REQ-003 clock  input  1  single clock; all state SHALL update on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 io_respValid  input  1  bus response valid; io_rdata SHALL be sampled this cycle.
REQ-006 io_rdata  input  32  bus read data.
REQ-007 io_addr  output  32  bus fetch address.
REQ-008 io_reqValid  output  1  bus request; held high until io_respValid.
REQ-009 redirect  input  1  flush-and-redirect strobe from the core.
REQ-010 redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-011 respReady  input  1  core accepts the head instruction.
REQ-012 respValid  output  1  head instruction valid.
REQ-013 inst  output  32  head instruction word.
REQ-014 inst_pc  output  32  address of head instruction.
REQ-015 count  output  $clog2(DEPTH+1)  buffer occupancy.
REQ-016 perf_fetch  output  32  accepted-fetch counter (see Configuration).
REQ-017 perf_drop  output  32  discarded-response counter (see Configuration).

Function
REQ-018 Buffer SHALL be a DEPTH-entry FIFO of {inst, pc}; head/tail pointers SHALL wrap modulo DEPTH.
REQ-019 FSM states IDLE, WAIT, DROP; at most one bus request outstanding.
REQ-020 IDLE, count<DEPTH, no redirect: io_reqValid=1, io_addr=fetch_pc, req_addr<=fetch_pc; io_respValid same cycle -> push, fetch_pc+=4, stay IDLE; else -> WAIT.
REQ-021 IDLE, count==DEPTH: io_reqValid=0, stay IDLE; issue condition uses the registered count (one bubble after a pop from full).
REQ-022 WAIT: io_reqValid=1, io_addr=req_addr stable; io_respValid -> push {io_rdata, req_addr}, fetch_pc+=4, -> IDLE.
REQ-023 DROP: io_reqValid=1, io_addr=req_addr; io_respValid -> discard data, -> IDLE.
REQ-024 fetch_pc SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4=0).
REQ-025 respValid = (count!=0) and not redirect; inst/inst_pc SHALL show the head entry; pop on respValid && respReady.
REQ-026 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-027 Latency: a pushed response SHALL appear on respValid the next cycle; no bypass.
REQ-028 redirect SHALL have priority over all events: FIFO cleared (count=0, pointers equalised), fetch_pc<=redirect_pc, no push, no pop, respValid=0 that cycle.
REQ-029 redirect in IDLE: io_reqValid=0 that cycle, next state IDLE.
REQ-030 redirect in WAIT with io_respValid=1: response discarded, -> IDLE; with io_respValid=0: -> DROP.
REQ-031 redirect in DROP: fetch_pc updated, stay DROP (or -> IDLE if io_respValid=1).

Reset
REQ-032 While reset is high: state IDLE, fetch_pc=RESET_PC, req_addr=RESET_PC, count=0, pointers=0, perf counters=0.
REQ-033 While reset is high: io_reqValid=0, respValid=0; io_addr=RESET_PC.
REQ-034 Reset mid-request SHALL abandon the outstanding request with no push; first post-reset request SHALL target RESET_PC.

Configuration
REQ-035 Macro IFU_PREFETCH_PERF_EN defined: perf_fetch SHALL increment on every push; perf_drop SHALL increment on every response discarded due to redirect (REQ-023, REQ-030, REQ-031); both wrap at 2^32.
REQ-036 Macro undefined: no counter registers; perf_fetch and perf_drop SHALL be tied to 0.

Verification
REQ-037 Reset release, zero-wait bus returning addr^32'h1, respReady=1 -> io_addr 8000_0000, 8000_0004, ...; inst_pc/inst matching in order, one instruction per cycle after first.
REQ-038 DEPTH=4, respReady=0, 1-cycle bus -> exactly 4 pushes, count=4, io_reqValid=0; then respReady=1 for one cycle -> pop 8000_0000, one bubble, fetch 8000_0010.
REQ-039 redirect to 32'h0000_1000 while WAIT, response 2 cycles later -> state DROP, response discarded, perf_drop=1 (macro on), next io_addr=0000_1000.
REQ-040 redirect coincident with io_respValid and respReady in WAIT with count=2 -> no push, no pop, count=0, respValid=0, next request 1 cycle later at redirect_pc.
REQ-041 redirect_pc=32'hFFFF_FFFC -> fetches FFFF_FFFC then 0000_0000.
REQ-042 reset asserted during WAIT -> io_reqValid=0 immediately, count=0; after release first io_addr=RESET_PC.

Source files
------------

// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - instruction prefetch unit with DEPTH-entry buffer
//
// Fetches sequential 32-bit instruction words over a single-outstanding bus
// and queues {inst, pc} pairs for the core.
//
// Ports:
//   clock, reset          single clock, asynchronous active-high reset
//   io_reqValid/io_addr   bus request (held until io_respValid)
//   io_respValid/io_rdata bus response
//   redirect/redirect_pc  flush buffer and restart fetch at redirect_pc
//   respValid/respReady   head-of-buffer handshake; inst/inst_pc are the head
//   count                 buffer occupancy
//   perf_fetch/perf_drop  push / discarded-response counters
//
// Optional feature macro: IFU_PREFETCH_PERF_EN enables the perf counters;
// without it perf_fetch and perf_drop are tied to zero.
module ifu_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         io_respValid,
  input  logic [31:0]                  io_rdata,
  output logic [31:0]                  io_addr,
  output logic                         io_reqValid,
  input  logic                         redirect,
  input  logic [31:0]                  redirect_pc,
  input  logic                         respReady,
  output logic                         respValid,
  output logic [31:0]                  inst,
  output logic [31:0]                  inst_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [31:0]                  perf_fetch,
  output logic [31:0]                  perf_drop
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, tail_q;
  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic          push, pop, drop;
  logic [31:0]   push_pc;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_addr_d  = req_addr_q;
    io_reqValid = 1'b0;
    io_addr     = req_addr_q;
    push        = 1'b0;
    push_pc     = req_addr_q;
    drop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        io_addr = fetch_pc_q;
        // Issue decision uses registered occupancy: a pop from full costs one bubble.
        if (!redirect && count_q != CW'(DEPTH)) begin
          io_reqValid = 1'b1;
          req_addr_d  = fetch_pc_q;
          push_pc     = fetch_pc_q;
          if (io_respValid) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        io_reqValid = 1'b1;
        if (io_respValid) begin
          state_d = S_IDLE;
          if (redirect) begin
            drop = 1'b1;
          end else begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end else if (redirect) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        // Stale request still in flight: swallow its response.
        io_reqValid = 1'b1;
        if (io_respValid) begin
          drop    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect) fetch_pc_d = redirect_pc;
    if (reset) io_reqValid = 1'b0;
  end

  assign respValid = (count_q != '0) && !redirect;
  assign pop       = respValid && respReady;
  assign inst      = inst_mem[head_q];
  assign inst_pc   = pc_mem[head_q];
  assign count     = count_q;

  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
    if (redirect) count_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      count_q    <= count_d;
      if (redirect) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (push) tail_q <= tail_q + PW'(1);
        if (pop)  head_q <= head_q + PW'(1);
      end
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clock) begin
    if (push && !redirect) begin
      inst_mem[tail_q] <= io_rdata;
      pc_mem[tail_q]   <= push_pc;
    end
  end

`ifdef IFU_PREFETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_drop_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_fetch_q <= '0;
      perf_drop_q  <= '0;
    end else begin
      if (push && !redirect) perf_fetch_q <= perf_fetch_q + 32'd1;
      if (drop)              perf_drop_q  <= perf_drop_q + 32'd1;
    end
  end

  assign perf_fetch = perf_fetch_q;
  assign perf_drop  = perf_drop_q;
`else
  logic unused_perf;
  assign unused_perf = drop;
  assign perf_fetch  = '0;
  assign perf_drop   = '0;
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - directed self-checking bench for ifu_prefetch
module tb_ifu_prefetch;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h8000_0000;
`ifdef IFU_PREFETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clock, reset;
  logic        io_respValid;
  logic [31:0] io_rdata;
  logic [31:0] io_addr;
  logic        io_reqValid;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        respReady;
  logic        respValid;
  logic [31:0] inst, inst_pc;
  logic [2:0]  count;
  logic [31:0] perf_fetch, perf_drop;

  int tests = 0;
  int fails = 0;

  ifu_prefetch #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clock(clock), .reset(reset),
    .io_respValid(io_respValid), .io_rdata(io_rdata),
    .io_addr(io_addr), .io_reqValid(io_reqValid),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .respReady(respReady), .respValid(respValid),
    .inst(inst), .inst_pc(inst_pc), .count(count),
    .perf_fetch(perf_fetch), .perf_drop(perf_drop)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Each cycle: inputs set just after a negedge, outputs sampled #1 later.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; io_respValid = 1'b0; io_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; respReady = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; io_respValid = 1'b1; io_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; respReady = 1'b1;
    @(negedge clock); #1;
    tests++; if (io_reqValid !== 1'b0) begin fails++; $display("FAIL rst_reqValid: got %b expected 0", io_reqValid); end
    tests++; if (respValid !== 1'b0) begin fails++; $display("FAIL rst_respValid: got %b expected 0", respValid); end
    tests++; if (io_addr !== RPC) begin fails++; $display("FAIL rst_addr: got %h expected %h", io_addr, RPC); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL rst_count: got %0d expected 0", count); end
    tests++; if (perf_fetch !== 32'd0 || perf_drop !== 32'd0) begin fails++; $display("FAIL rst_perf: got %h/%h expected 0/0", perf_fetch, perf_drop); end
    io_respValid = 1'b0;
    @(negedge clock);
    reset = 1'b0; #1;
    tests++; if (io_reqValid !== 1'b1 || io_addr !== RPC) begin fails++; $display("FAIL rst_first_req: got %b/%h expected 1/%h", io_reqValid, io_addr, RPC); end
  endtask

  task automatic test_stream();
    logic [31:0] ea;
    do_reset();
    io_respValid = 1'b1; respReady = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ea = RPC + 32'(4 * k);
      io_rdata = ea ^ 32'h1; #1;
      tests++; if (io_reqValid !== 1'b1 || io_addr !== ea) begin fails++; $display("FAIL stream_req%0d: got %b/%h expected 1/%h", k, io_reqValid, io_addr, ea); end
      if (k == 0) begin
        tests++; if (respValid !== 1'b0) begin fails++; $display("FAIL stream_nobypass: got %b expected 0", respValid); end
      end else begin
        tests++; if (respValid !== 1'b1 || inst_pc !== ea - 32'd4 || inst !== ((ea - 32'd4) ^ 32'h1))
          begin fails++; $display("FAIL stream_head%0d: got %b/%h/%h expected 1/%h/%h", k, respValid, inst_pc, inst, ea - 32'd4, (ea - 32'd4) ^ 32'h1); end
      end
      @(negedge clock);
    end
    io_respValid = 1'b0; #1;
    tests++; if (count !== 3'd1) begin fails++; $display("FAIL stream_count: got %0d expected 1", count); end
    tests++; if (perf_fetch !== (PERF ? 32'd6 : 32'd0)) begin fails++; $display("FAIL stream_perf_fetch: got %0d expected %0d", perf_fetch, PERF ? 6 : 0); end
  endtask

  task automatic test_full();
    logic [31:0] ea;
    do_reset();
    io_respValid = 1'b1; respReady = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ea = RPC + 32'(4 * k);
      io_rdata = ea ^ 32'h1; #1;
      tests++; if (io_reqValid !== 1'b1 || io_addr !== ea || count !== 3'(k))
        begin fails++; $display("FAIL full_fill%0d: got %b/%h/%0d expected 1/%h/%0d", k, io_reqValid, io_addr, count, ea, k); end
      @(negedge clock);
    end
    for (int k = 0; k < 2; k++) begin
      #1;
      tests++; if (count !== 3'd4 || io_reqValid !== 1'b0) begin fails++; $display("FAIL full_stall%0d: got %0d/%b expected 4/0", k, count, io_reqValid); end
      @(negedge clock);
    end
    respReady = 1'b1; #1;
    tests++; if (respValid !== 1'b1 || inst_pc !== RPC || inst !== (RPC ^ 32'h1) || io_reqValid !== 1'b0)
      begin fails++; $display("FAIL full_pop: got %b/%h/%h/%b expected 1/%h/%h/0", respValid, inst_pc, inst, io_reqValid, RPC, RPC ^ 32'h1); end
    @(negedge clock);
    respReady = 1'b0; io_rdata = (RPC + 32'h10) ^ 32'h1; #1;
    tests++; if (count !== 3'd3 || io_reqValid !== 1'b1 || io_addr !== RPC + 32'h10 || inst_pc !== RPC + 32'h4)
      begin fails++; $display("FAIL full_refetch: got %0d/%b/%h/%h expected 3/1/%h/%h", count, io_reqValid, io_addr, inst_pc, RPC + 32'h10, RPC + 32'h4); end
    @(negedge clock);
    io_respValid = 1'b0; #1;
    tests++; if (count !== 3'd4 || io_reqValid !== 1'b0) begin fails++; $display("FAIL full_refill: got %0d/%b expected 4/0", count, io_reqValid); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    io_respValid = 1'b0; #1;
    tests++; if (io_reqValid !== 1'b1 || io_addr !== RPC) begin fails++; $display("FAIL rdw_issue: got %b/%h expected 1/%h", io_reqValid, io_addr, RPC); end
    @(negedge clock);
    redirect = 1'b1; redirect_pc = 32'h0000_1000; #1;
    tests++; if (io_reqValid !== 1'b1 || io_addr !== RPC || respValid !== 1'b0)
      begin fails++; $display("FAIL rdw_hold: got %b/%h/%b expected 1/%h/0", io_reqValid, io_addr, respValid, RPC); end
    @(negedge clock);
    redirect = 1'b0; #1;
    tests++; if (io_reqValid !== 1'b1 || io_addr !== RPC) begin fails++; $display("FAIL rdw_drop_hold: got %b/%h expected 1/%h", io_reqValid, io_addr, RPC); end
    @(negedge clock);
    io_respValid = 1'b1; io_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    io_respValid = 1'b0; #1;
    tests++; if (count !== 3'd0 || respValid !== 1'b0) begin fails++; $display("FAIL rdw_discard: got %0d/%b expected 0/0", count, respValid); end
    tests++; if (io_reqValid !== 1'b1 || io_addr !== 32'h0000_1000) begin fails++; $display("FAIL rdw_newaddr: got %b/%h expected 1/00001000", io_reqValid, io_addr); end
    tests++; if (perf_drop !== (PERF ? 32'd1 : 32'd0) || perf_fetch !== 32'd0)
      begin fails++; $display("FAIL rdw_perf: got %0d/%0d expected %0d/0", perf_drop, perf_fetch, PERF ? 1 : 0); end
  endtask

  task automatic test_redirect_coincident();
    do_reset();
    io_respValid = 1'b1; respReady = 1'b0;
    for (int k = 0; k < 2; k++) begin
      io_rdata = (RPC + 32'(4 * k)) ^ 32'h1;
      @(negedge clock);
    end
    io_respValid = 1'b0; #1;
    tests++; if (count !== 3'd2 || io_addr !== RPC + 32'h8) begin fails++; $display("FAIL rdc_setup: got %0d/%h expected 2/%h", count, io_addr, RPC + 32'h8); end
    @(negedge clock);
    redirect = 1'b1; redirect_pc = 32'h0000_2000; io_respValid = 1'b1; io_rdata = 32'h1234_5678; respReady = 1'b1; #1;
    tests++; if (respValid !== 1'b0 || io_reqValid !== 1'b1) begin fails++; $display("FAIL rdc_mask: got %b/%b expected 0/1", respValid, io_reqValid); end
    @(negedge clock);
    redirect = 1'b0; io_respValid = 1'b0; respReady = 1'b0; #1;
    tests++; if (count !== 3'd0 || respValid !== 1'b0) begin fails++; $display("FAIL rdc_flush: got %0d/%b expected 0/0", count, respValid); end
    tests++; if (io_reqValid !== 1'b1 || io_addr !== 32'h0000_2000) begin fails++; $display("FAIL rdc_newaddr: got %b/%h expected 1/00002000", io_reqValid, io_addr); end
    tests++; if (perf_fetch !== (PERF ? 32'd2 : 32'd0) || perf_drop !== (PERF ? 32'd1 : 32'd0))
      begin fails++; $display("FAIL rdc_perf: got %0d/%0d expected %0d/%0d", perf_fetch, perf_drop, PERF ? 2 : 0, PERF ? 1 : 0); end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
    tests++; if (io_reqValid !== 1'b0) begin fails++; $display("FAIL wrap_idle_redirect: got %b expected 0", io_reqValid); end
    @(negedge clock);
    redirect = 1'b0; io_respValid = 1'b1; io_rdata = 32'hAAAA_0001; respReady = 1'b1; #1;
    tests++; if (io_reqValid !== 1'b1 || io_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_first: got %b/%h expected 1/fffffffc", io_reqValid, io_addr); end
    @(negedge clock);
    io_rdata = 32'hAAAA_0002; #1;
    tests++; if (io_addr !== 32'h0000_0000 || inst_pc !== 32'hFFFF_FFFC || inst !== 32'hAAAA_0001)
      begin fails++; $display("FAIL wrap_second: got %h/%h/%h expected 00000000/fffffffc/aaaa0001", io_addr, inst_pc, inst); end
    @(negedge clock);
    io_respValid = 1'b0; #1;
    tests++; if (respValid !== 1'b1 || inst_pc !== 32'h0000_0000 || inst !== 32'hAAAA_0002)
      begin fails++; $display("FAIL wrap_head: got %b/%h/%h expected 1/00000000/aaaa0002", respValid, inst_pc, inst); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    io_respValid = 1'b1; io_rdata = 32'h5555_0000; respReady = 1'b0;
    @(negedge clock);
    io_respValid = 1'b0;
    @(negedge clock);
    #1;
    tests++; if (io_reqValid !== 1'b1 || io_addr !== RPC + 32'h4 || count !== 3'd1)
      begin fails++; $display("FAIL rmid_wait: got %b/%h/%0d expected 1/%h/1", io_reqValid, io_addr, count, RPC + 32'h4); end
    reset = 1'b1; #1;
    tests++; if (io_reqValid !== 1'b0 || count !== 3'd0 || respValid !== 1'b0 || io_addr !== RPC)
      begin fails++; $display("FAIL rmid_async: got %b/%0d/%b/%h expected 0/0/0/%h", io_reqValid, count, respValid, io_addr, RPC); end
    io_respValid = 1'b1; io_rdata = 32'h6666_0000;
    @(negedge clock);
    io_respValid = 1'b0; reset = 1'b0; #1;
    tests++; if (io_reqValid !== 1'b1 || io_addr !== RPC || count !== 3'd0)
      begin fails++; $display("FAIL rmid_release: got %b/%h/%0d expected 1/%h/0", io_reqValid, io_addr, count, RPC); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect_wait();
    test_redirect_coincident();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
